// File: rtl/iir_biquad_tdm.sv
// Time-multiplexed biquad IIR section with per-channel history and a double-buffered coefficient bank.
// Define IIR_BIQUAD_SAT_EN to saturate the output; otherwise the output wraps to DATA_W bits.
module iir_biquad_tdm #(
  parameter int DATA_W   = 15,
  parameter int COEF_W   = 12,
  parameter int A0_SHIFT = 9,
  parameter int NCH      = 4,
  parameter int CH_W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] din,
  input  logic        [CH_W-1:0]   din_ch,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [DATA_W-1:0] dout,
  output logic        [CH_W-1:0]   dout_ch,
  output logic                     dout_valid,
  input  logic                     coef_we,
  input  logic        [2:0]        coef_sel,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_commit,
  output logic                     commit_pend,
  output logic                     ovf
);

  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + 3;
  localparam logic signed [COEF_W-1:0] B0_ONE = COEF_W'(2 ** A0_SHIFT);
  localparam logic [CH_W:0] NCH_EXT = NCH[CH_W:0];

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM} state_t;

  state_t state_q, state_d;
  logic   din_ready_q, commit_pend_q, commit_pend_d, ovf_q;
  logic   dout_valid_q;
  logic signed [DATA_W-1:0] dout_q;
  logic        [CH_W-1:0]   dout_ch_q;

  // Bank order: b0, b1, b2, a1, a2
  logic signed [COEF_W-1:0] sh_q  [5];
  logic signed [COEF_W-1:0] act_q [5];

  logic signed [DATA_W-1:0] x1_q [NCH];
  logic signed [DATA_W-1:0] x2_q [NCH];
  logic signed [DATA_W-1:0] y1_q [NCH];
  logic signed [DATA_W-1:0] y2_q [NCH];

  logic signed [DATA_W-1:0] x_q, hx1_q, hx2_q, hy1_q, hy2_q;
  logic        [CH_W-1:0]   ch_q;
  logic signed [PW-1:0]     p_q [5];

  logic                     accept, ch_ok, commit_now, fits;
  logic signed [ACC_W-1:0]  acc, shifted;
  logic signed [DATA_W-1:0] y_wrap, y;

  always_comb begin
    ch_ok         = ({1'b0, din_ch} < NCH_EXT);
    accept        = (state_q == S_IDLE) && din_valid && din_ready_q;
    commit_now    = (state_q == S_IDLE) && (coef_commit || commit_pend_q);
    commit_pend_d = commit_now ? 1'b0 : (commit_pend_q | coef_commit);
    state_d       = state_q;
    case (state_q)
      S_IDLE:  if (accept && ch_ok) state_d = S_MUL;
      S_MUL:   state_d = S_SUM;
      S_SUM:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc     = ACC_W'(p_q[0]) + ACC_W'(p_q[1]) + ACC_W'(p_q[2])
            - ACC_W'(p_q[3]) - ACC_W'(p_q[4]);
    shifted = acc >>> A0_SHIFT;
    y_wrap  = shifted[DATA_W-1:0];
    fits    = (shifted == ACC_W'(y_wrap));
`ifdef IIR_BIQUAD_SAT_EN
    if (fits)                  y = y_wrap;
    else if (shifted[ACC_W-1]) y = {1'b1, {(DATA_W-1){1'b0}}};
    else                       y = {1'b0, {(DATA_W-1){1'b1}}};
`else
    y = y_wrap;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      din_ready_q   <= 1'b0;
      commit_pend_q <= 1'b0;
      ovf_q         <= 1'b0;
      dout_q        <= '0;
      dout_ch_q     <= '0;
      dout_valid_q  <= 1'b0;
      sh_q          <= '{B0_ONE, '0, '0, '0, '0};
      act_q         <= '{B0_ONE, '0, '0, '0, '0};
      x1_q          <= '{default: '0};
      x2_q          <= '{default: '0};
      y1_q          <= '{default: '0};
      y2_q          <= '{default: '0};
      x_q           <= '0;
      hx1_q         <= '0;
      hx2_q         <= '0;
      hy1_q         <= '0;
      hy2_q         <= '0;
      ch_q          <= '0;
      p_q           <= '{default: '0};
    end else begin
      state_q       <= state_d;
      din_ready_q   <= (state_d == S_IDLE);
      commit_pend_q <= commit_pend_d;
      dout_valid_q  <= 1'b0;

      // Copy reads the pre-write shadow value when a write lands on the same edge.
      if (commit_now) act_q <= sh_q;
      if (coef_we) begin
        case (coef_sel)
          3'd0:    sh_q[0] <= coef_wdata;
          3'd1:    sh_q[1] <= coef_wdata;
          3'd2:    sh_q[2] <= coef_wdata;
          3'd3:    sh_q[3] <= coef_wdata;
          3'd4:    sh_q[4] <= coef_wdata;
          default: ;
        endcase
      end

      if (accept && ch_ok) begin
        x_q   <= din;
        ch_q  <= din_ch;
        hx1_q <= x1_q[din_ch];
        hx2_q <= x2_q[din_ch];
        hy1_q <= y1_q[din_ch];
        hy2_q <= y2_q[din_ch];
      end

      if (state_q == S_MUL) begin
        p_q[0] <= PW'(act_q[0]) * PW'(x_q);
        p_q[1] <= PW'(act_q[1]) * PW'(hx1_q);
        p_q[2] <= PW'(act_q[2]) * PW'(hx2_q);
        p_q[3] <= PW'(act_q[3]) * PW'(hy1_q);
        p_q[4] <= PW'(act_q[4]) * PW'(hy2_q);
      end

      if (state_q == S_SUM) begin
        dout_q       <= y;
        dout_ch_q    <= ch_q;
        dout_valid_q <= 1'b1;
        x2_q[ch_q]   <= hx1_q;
        x1_q[ch_q]   <= x_q;
        y2_q[ch_q]   <= hy1_q;
        y1_q[ch_q]   <= y;
        if (!fits) ovf_q <= 1'b1;
      end
    end
  end

  assign din_ready   = din_ready_q;
  assign dout        = dout_q;
  assign dout_ch     = dout_ch_q;
  assign dout_valid  = dout_valid_q;
  assign commit_pend = commit_pend_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Self-checking bench for iir_biquad_tdm: scoreboard of expected outputs plus timing/commit/reset sequences.
module tb_iir_biquad_tdm;
  localparam int DATA_W = 15, COEF_W = 12, A0_SHIFT = 9, NCH = 4, CH_W = 2;
  localparam longint YMAX = (64'sd1 <<< (DATA_W - 1)) - 1;
  localparam longint YMIN = -(64'sd1 <<< (DATA_W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [DATA_W-1:0] din = '0;
  logic [CH_W-1:0] din_ch = '0;
  logic din_valid = 1'b0;
  logic din_ready;
  logic signed [DATA_W-1:0] dout;
  logic [CH_W-1:0] dout_ch;
  logic dout_valid;
  logic coef_we = 1'b0;
  logic [2:0] coef_sel = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
  logic coef_commit = 1'b0;
  logic commit_pend, ovf;

  iir_biquad_tdm #(.DATA_W(DATA_W), .COEF_W(COEF_W), .A0_SHIFT(A0_SHIFT), .NCH(NCH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_ch(din_ch), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .coef_we(coef_we), .coef_sel(coef_sel),
    .coef_wdata(coef_wdata), .coef_commit(coef_commit), .commit_pend(commit_pend), .ovf(ovf));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct { int ch; int val; } exp_t;
  exp_t sbq[$];

  typedef struct { int din; int ch; int exp; } vec_t;
  vec_t vt[5];

  longint m_sh[5], m_act[5];
  longint m_x1[NCH], m_x2[NCH], m_y1[NCH], m_y2[NCH];
  bit m_ovf;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      m_sh[i] = 0;
      m_act[i] = 0;
    end
    m_sh[0] = 1 <<< A0_SHIFT;
    m_act[0] = 1 <<< A0_SHIFT;
    for (int c = 0; c < NCH; c++) begin
      m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
    end
    m_ovf = 0;
  endfunction

  // Golden model: a0*y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, floor-divided by a0.
  function automatic longint model_step(input int ch, input longint x);
    longint acc, sh, r;
    acc = m_act[0] * x + m_act[1] * m_x1[ch] + m_act[2] * m_x2[ch]
        - m_act[3] * m_y1[ch] - m_act[4] * m_y2[ch];
    sh = acc >>> A0_SHIFT;
`ifdef IIR_BIQUAD_SAT_EN
    r = (sh > YMAX) ? YMAX : (sh < YMIN) ? YMIN : sh;
`else
    r = sh & ((64'sd1 <<< DATA_W) - 1);
    if (r > YMAX) r = r - (64'sd1 <<< DATA_W);
`endif
    if (r != sh) m_ovf = 1;
    m_x2[ch] = m_x1[ch];
    m_x1[ch] = x;
    m_y2[ch] = m_y1[ch];
    m_y1[ch] = r;
    return r;
  endfunction

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_dout_valid: got dout=%0d ch=%0d, want no output", dout, dout_ch);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("dout", longint'(dout), e.val);
        chk("dout_ch", longint'(dout_ch), e.ch);
      end
    end
  end

  // All driving tasks enter and leave 1 time unit after a rising edge.
  task automatic wait_ready();
    for (int i = 0; i < 50 && !din_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("din_ready_wait", longint'(din_ready), 1);
  endtask

  task automatic send(input int ch, input int x, input bit use_exp, input int exp_v);
    longint y;
    wait_ready();
    din = DATA_W'(x); din_ch = CH_W'(ch); din_valid = 1'b1;
    y = model_step(ch, x);
    sbq.push_back('{ch, use_exp ? exp_v : int'(y)});
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic write_coef(input int sel, input int val);
    coef_we = 1'b1; coef_sel = 3'(sel); coef_wdata = COEF_W'(val);
    if (sel < 5) m_sh[sel] = val;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic load_bank(input int b0, input int b1, input int b2, input int a1, input int a2);
    write_coef(0, b0); write_coef(1, b1); write_coef(2, b2); write_coef(3, a1); write_coef(4, a2);
  endtask

  task automatic commit_idle();
    coef_commit = 1'b1;
    @(posedge clk); #1;
    coef_commit = 1'b0;
    for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
    chk("commit_pend_after_idle_commit", longint'(commit_pend), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drain", sbq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{512, 0, 256};
    vt[1] = '{0, 0, 256};
    vt[2] = '{0, 0, 0};
    vt[3] = '{0, 0, 0};
    vt[4] = '{0, 1, 0};
    model_reset();

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_dout_valid", longint'(dout_valid), 0);
    chk("rst_commit_pend", longint'(commit_pend), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_din_ready", longint'(din_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("din_ready_after_rst", longint'(din_ready), 1);

    // Passthrough sample with exact latency and ready timing
    @(posedge clk); #1;
    din = 15'sd1000; din_ch = 2'd2; din_valid = 1'b1;
    sbq.push_back('{2, int'(model_step(2, 1000))});
    @(posedge clk); #1 din_valid = 1'b0;
    @(negedge clk);
    chk("ready_low_c1", longint'(din_ready), 0);
    chk("valid_low_c1", longint'(dout_valid), 0);
    @(negedge clk);
    chk("ready_low_c2", longint'(din_ready), 0);
    chk("valid_low_c2", longint'(dout_valid), 0);
    @(negedge clk);
    chk("valid_c3", longint'(dout_valid), 1);
    chk("dout_c3", longint'(dout), 1000);
    chk("dout_ch_c3", longint'(dout_ch), 2);
    chk("ready_back_c3", longint'(din_ready), 1);
    @(negedge clk);
    chk("valid_one_cycle", longint'(dout_valid), 0);
    chk("dout_hold", longint'(dout), 1000);
    @(posedge clk); #1;

    // FIR taps b0=b1=256 via table
    load_bank(256, 256, 0, 0, 0);
    commit_idle();
    for (int i = 0; i < 5; i++) send(vt[i].ch, vt[i].din, 1'b1, vt[i].exp);
    drain();

    // Integrator up to and past full scale
    load_bank(512, 0, 0, -512, 0);
    commit_idle();
    for (int i = 0; i < 160; i++) send(1, 100, 1'b0, 0);
    drain();
    chk("ovf_before_limit", longint'(ovf), 0);
    for (int i = 0; i < 10; i++) send(1, 100, 1'b0, 0);
    drain();
    chk("ovf_after_limit", longint'(ovf), 1);
    chk("ovf_model", longint'(ovf), longint'(m_ovf));

    // Bandpass, interleaved ch0 / ch3
    load_bank(100, 0, -100, -800, 400);
    commit_idle();
    for (int i = 0; i < 30; i++) begin
      send(0, int'($urandom_range(0, 12000)) - 6000, 1'b0, 0);
      send(3, ((i / 3) % 2 == 0) ? 3000 : -3000, 1'b0, 0);
    end
    drain();

    // Commit pulsed during MUL: in-flight sample keeps old bank
    load_bank(1024, 0, 0, 0, 0);
    write_coef(5, 77);
    wait_ready();
    din = 15'sd300; din_ch = 2'd3; din_valid = 1'b1;
    sbq.push_back('{3, int'(model_step(3, 300))});
    @(posedge clk); #1;
    din_valid = 1'b0; coef_commit = 1'b1;
    @(posedge clk); #1;
    coef_commit = 1'b0;
    chk("commit_pend_in_sum", longint'(commit_pend), 1);
    @(posedge clk); #1;
    chk("commit_pend_after_sum", longint'(commit_pend), 1);
    @(posedge clk); #1;
    chk("commit_pend_cleared_idle", longint'(commit_pend), 0);
    for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
    send(3, 300, 1'b1, 600);
    drain();

    // Commit coinciding with accept: new bank applies to that sample
    write_coef(0, 512);
    wait_ready();
    din = -15'sd777; din_ch = 2'd0; din_valid = 1'b1; coef_commit = 1'b1;
    for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
    sbq.push_back('{0, int'(model_step(0, -777))});
    @(posedge clk); #1;
    din_valid = 1'b0; coef_commit = 1'b0;
    drain();

    // Reset during SUM aborts the sample
    wait_ready();
    din = 15'sd5000; din_ch = 2'd0; din_valid = 1'b1;
    @(posedge clk); #1 din_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_valid", longint'(dout_valid), 0);
    chk("abort_dout_zero", longint'(dout), 0);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    send(1, -1234, 1'b1, -1234);
    drain();
    chk("ovf_after_reset", longint'(ovf), 0);
    chk("commit_pend_after_reset", longint'(commit_pend), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
